// File: rtl/pixel_row_loader.sv
// Fetches one pixel row over Avalon-MM and streams it to the row register.
// Ports: clk/rst, start/base_addr, mem_* read master, clean/enable/iterator/data_out, busy/done.
module pixel_row_loader #(
  parameter int NUM_PIXELS      = 160,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_readdata,
  output logic        clean,
  output logic        enable,
  output logic [15:0] iterator,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  localparam int WORDS = NUM_PIXELS / 4;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FETCH,
    DONE
  } state_t;

  state_t      state, state_d;
  logic [15:0] issued, issued_d;
  logic [15:0] received, received_d;
  logic [31:0] base_q, base_d;

  logic        mem_read_d;
  logic [31:0] addr_d;
  logic        clean_d;
  logic        enable_d;
  logic [15:0] iter_d;
  logic [31:0] data_d;
  logic        busy_d;
  logic        done_d;

  logic        accept;
  logic        ret;
  logic [15:0] pend_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issued      <= '0;
      received    <= '0;
      base_q      <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      clean       <= 1'b0;
      enable      <= 1'b0;
      iterator    <= '0;
      data_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      issued      <= issued_d;
      received    <= received_d;
      base_q      <= base_d;
      mem_read    <= mem_read_d;
      mem_address <= addr_d;
      clean       <= clean_d;
      enable      <= enable_d;
      iterator    <= iter_d;
      data_out    <= data_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    issued_d   = issued;
    received_d = received;
    base_d     = base_q;
    enable_d   = 1'b0;
    iter_d     = iterator;
    data_d     = data_out;
    accept     = 1'b0;
    ret        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          issued_d   = '0;
          received_d = '0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        state_d = FETCH;
      end
      FETCH: begin
        accept = mem_read & ~mem_waitrequest;
        // Returns with nothing in flight are stray and dropped.
        ret    = mem_readdatavalid & (issued != received);
        if (accept) begin
          issued_d = issued + 16'd1;
        end
        if (ret) begin
          received_d = received + 16'd1;
          enable_d   = 1'b1;
          data_d     = mem_readdata;
          iter_d     = {received[13:0], 2'b00};
        end
        if (received == 16'(WORDS)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered request: computed from next-cycle counters, so a
    // stalled request keeps its address (issued does not move).
    pend_d     = issued_d - received_d;
    mem_read_d = (state_d == FETCH) &&
                 (issued_d < 16'(WORDS)) &&
                 (pend_d < 16'(MAX_OUTSTANDING));
    addr_d     = mem_address;
    if (state_d == FETCH) begin
      addr_d = base_d + (32'(issued_d) << 2);
    end

    clean_d = (state_d == CLEAR);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_pixel_row_loader.sv
// Randomized self-checking bench for pixel_row_loader.
// Slave model, request/return scoreboard and per-cycle output expectations.
module tb_pixel_row_loader;

  localparam int NP    = 160;
  localparam int MO    = 4;
  localparam int WORDS = NP / 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;
  logic [31:0] mem_readdata;
  logic        clean;
  logic        enable;
  logic [15:0] iterator;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  pixel_row_loader #(
    .NUM_PIXELS(NP),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata),
    .clean(clean),
    .enable(enable),
    .iterator(iterator),
    .data_out(data_out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Row content: byte i of the word at offset o is (o+i)^salt.
  function automatic logic [31:0] mem_word(logic [31:0] a, logic [31:0] b,
                                           logic [7:0] salt);
    logic [31:0] o;
    logic [31:0] w;
    o = a - b;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = 8'(o + 32'(i)) ^ salt;
    end
    return w;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rq_t;

  rq_t q[$];

  task automatic run_load(logic [31:0] base, int p_wait, int lat,
                          logic [7:0] salt, int abort_at,
                          int restart_at, int exp_max);
    int cyc      = 0;
    int n_acc    = 0;
    int n_ret    = 0;
    int n_en     = 0;
    int last_en  = -10;
    int first_en = -1;
    int max_out  = 0;
    bit prev_v   = 1'b0;
    bit fin      = 1'b0;
    bit aborted  = 1'b0;
    bit exp_req;
    q.delete();
    @(posedge clk);
    #1;
    start             = 1'b1;
    base_addr         = base;
    mem_waitrequest   = ($urandom_range(99) < p_wait);
    mem_readdatavalid = 1'b0;
    mem_readdata      = $urandom;
    while (!fin) begin
      @(negedge clk);
      check("clean", 32'(clean), 32'(cyc == 1));
      exp_req = (cyc >= 2) && (n_acc < WORDS) && (n_acc - n_ret < MO);
      check("mem_read", 32'(mem_read), 32'(exp_req));
      if (mem_read) begin
        check("addr", mem_address, base + 32'(4 * n_acc));
        if (!mem_waitrequest) begin
          q.push_back('{cyc + lat, mem_address});
          n_acc++;
        end
      end
      check("enable", 32'(enable), 32'(prev_v));
      if (enable) begin
        if (first_en < 0) first_en = cyc;
        check("iter", 32'(iterator), 32'(4 * n_en));
        check("data", data_out, mem_word(base + 32'(4 * n_en), base, salt));
        n_en++;
        if (n_en == WORDS) last_en = cyc;
      end
      check("done", 32'(done), 32'(n_en == WORDS && cyc == last_en + 1));
      check("busy", 32'(busy),
            32'(cyc >= 1 && !(n_en == WORDS && cyc > last_en + 1)));
      if (n_acc - n_ret > max_out) max_out = n_acc - n_ret;
      prev_v = mem_readdatavalid;
      if (mem_readdatavalid) n_ret++;
      if (n_en == WORDS && cyc == last_en + 2) fin = 1'b1;
      if (cyc > 3000) begin
        check("timeout", 32'(n_en), 32'(WORDS));
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk);
        #1;
        cyc++;
        start           = (cyc == restart_at);
        base_addr       = (cyc == restart_at) ? (base ^ 32'h5555_0000) : base;
        mem_waitrequest = ($urandom_range(99) < p_wait);
        if (q.size() > 0 && q[0].due <= cyc) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = mem_word(q[0].addr, base, salt);
          void'(q.pop_front());
        end else begin
          mem_readdatavalid = 1'b0;
          mem_readdata      = $urandom;
        end
        if (cyc == abort_at) begin
          aborted = 1'b1;
          fin     = 1'b1;
        end
      end
    end
    if (!aborted) begin
      check("n_acc", 32'(n_acc), 32'(WORDS));
      if (exp_max >= 0) check("max_out", 32'(max_out), 32'(exp_max));
      else check("max_out_le", 32'(max_out <= MO), 32'd1);
      if (lat == 1 && p_wait == 0) check("first_en", 32'(first_en), 32'd4);
    end
  endtask

  initial begin
    rst               = 1'b1;
    start             = 1'b0;
    base_addr         = '0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_iter", 32'(iterator), 32'd0);
    check("rst_data", data_out, 32'd0);
    rst = 1'b0;

    // basic row, zero-wait slave, 1-cycle latency
    run_load(32'h0000_1000, 0, 1, 8'h00, -1, -1, -1);
    // backpressure
    run_load(32'h0002_0040, 50, 2, 8'h3C, -1, -1, -1);
    // outstanding limit
    run_load(32'h0000_8000, 0, 10, 8'hA5, -1, -1, MO);
    // start ignored mid-fetch
    run_load(32'h0000_4000, 30, 3, 8'h11, -1, 10, -1);
    // address wrap
    run_load(32'hFFFF_FF80, 20, 2, 8'h77, -1, -1, -1);

    // reset mid-fetch
    run_load(32'h0000_2000, 0, 3, 8'h00, 12, -1, -1);
    #2 rst = 1'b1;
    #1;
    check("arst_read", 32'(mem_read), 32'd0);
    check("arst_addr", mem_address, 32'd0);
    check("arst_clean", 32'(clean), 32'd0);
    check("arst_en", 32'(enable), 32'd0);
    check("arst_iter", 32'(iterator), 32'd0);
    check("arst_data", data_out, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    start             = 1'b0;
    mem_readdatavalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = $urandom;
      @(negedge clk);
      check("stray_en", 32'(enable), 32'd0);
      check("stray_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end
    mem_readdatavalid = 1'b0;
    @(negedge clk);
    check("stray_en", 32'(enable), 32'd0);
    run_load(32'h0000_2000, 0, 1, 8'h00, -1, -1, -1);

    // random loads
    for (int n = 0; n < 3; n++) begin
      run_load(32'($urandom) & 32'hFFFF_FFFC, int'($urandom_range(70)),
               int'($urandom_range(12, 1)), 8'($urandom), -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
